// File: rtl/icache_mem_assoc_pkg.sv
// Shared constants and FSM encoding for the set-associative instruction cache array.
package icache_mem_assoc_pkg;

    localparam int DEF_NUM_SETS = 64;
    localparam int DEF_NUM_WAYS = 2;
    localparam int DEF_DATA_W   = 64;
    localparam int DEF_TAG_W    = 23;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/icache_lru_update.sv
// True-LRU age update for one set: touched way becomes age 0, younger ways age by one.
module icache_lru_update #(
    parameter int NUM_WAYS = 2,
    parameter int WAY_W    = 1
) (
    input  logic                               en_i,
    input  logic [WAY_W-1:0]                   way_i,
    input  logic [NUM_WAYS-1:0][WAY_W-1:0]     age_i,
    output logic [NUM_WAYS-1:0][WAY_W-1:0]     age_o
);

    always_comb begin
        age_o = age_i;
        if (en_i) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == way_i) begin
                    age_o[w] = '0;
                end else if (age_i[w] < age_i[way_i]) begin
                    age_o[w] = age_i[w] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/icache_mem_assoc.sv
// Set-associative tag/data store with combinational lookup, LRU fill and a set-by-set flush sweep.
module icache_mem_assoc
    import icache_mem_assoc_pkg::*;
#(
    parameter  int NUM_SETS = DEF_NUM_SETS,
    parameter  int NUM_WAYS = DEF_NUM_WAYS,
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int TAG_W    = DEF_TAG_W,
    localparam int IDX_W    = $clog2(NUM_SETS),
    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              rd_en_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [TAG_W-1:0]  rd_tag_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic [WAY_W-1:0]  rd_way_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              flush_req_i,
    output logic              flush_busy_o
);

    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q;
    logic [TAG_W-1:0]                  tag_q  [NUM_SETS][NUM_WAYS];
    logic [DATA_W-1:0]                 data_q [NUM_SETS][NUM_WAYS];

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  flush_ptr_q, flush_ptr_d;
    logic              flush_busy;
    logic              wr_fire;
    logic [NUM_WAYS-1:0] hit_vec;
    logic [WAY_W-1:0]  hit_way, victim_way, lru_way;
    logic              victim_found;

    assign flush_busy   = (state_q == ST_FLUSH);
    assign flush_busy_o = flush_busy;
    assign wr_fire      = wr_en_i && !flush_busy;

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = valid_q[rd_idx_i][w] && (tag_q[rd_idx_i][w] == rd_tag_i);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    assign rd_valid_o = rd_en_i && !flush_busy && (|hit_vec);
    assign rd_way_o   = rd_valid_o ? hit_way : '0;
    assign rd_data_o  = rd_valid_o ? data_q[rd_idx_i][hit_way] : '0;

    // Refill in place, else first empty way, else evict the LRU way.
    always_comb begin
        victim_way   = lru_way;
        victim_found = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!victim_found && valid_q[wr_idx_i][w] && (tag_q[wr_idx_i][w] == wr_tag_i)) begin
                victim_way   = WAY_W'(w);
                victim_found = 1'b1;
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!victim_found && !valid_q[wr_idx_i][w]) begin
                victim_way   = WAY_W'(w);
                victim_found = 1'b1;
            end
        end
    end

    if (NUM_WAYS > 1) begin : g_lru
        logic [NUM_SETS-1:0][NUM_WAYS-1:0][WAY_W-1:0] age_q;
        logic [NUM_WAYS-1:0][WAY_W-1:0]               age_rd, age_fill_base, age_fill;

        icache_lru_update #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_lru_rd (
            .en_i  (rd_valid_o),
            .way_i (rd_way_o),
            .age_i (age_q[rd_idx_i]),
            .age_o (age_rd)
        );

        // A same-set read hit is folded in before the fill so the filled way ends MRU.
        assign age_fill_base = (rd_valid_o && (rd_idx_i == wr_idx_i)) ? age_rd : age_q[wr_idx_i];

        icache_lru_update #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_lru_fill (
            .en_i  (wr_fire),
            .way_i (victim_way),
            .age_i (age_fill_base),
            .age_o (age_fill)
        );

        always_comb begin
            lru_way = '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_fill_base[w] == WAY_W'(NUM_WAYS - 1)) lru_way = WAY_W'(w);
            end
        end

        always_ff @(posedge clock_i) begin
            if (reset_i) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    for (int w = 0; w < NUM_WAYS; w++) begin
                        age_q[s][w] <= WAY_W'(w);
                    end
                end
            end else begin
                if (rd_valid_o) age_q[rd_idx_i] <= age_rd;
                if (wr_fire)    age_q[wr_idx_i] <= age_fill;
            end
        end
    end else begin : g_dm
        assign lru_way = '0;
    end

    always_comb begin
        state_d     = state_q;
        flush_ptr_d = flush_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_req_i) begin
                    state_d     = ST_FLUSH;
                    flush_ptr_d = '0;
                end
            end
            ST_FLUSH: begin
                if (flush_ptr_q == IDX_W'(NUM_SETS - 1)) begin
                    state_d     = ST_IDLE;
                    flush_ptr_d = '0;
                end else begin
                    flush_ptr_d = flush_ptr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            flush_ptr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            flush_ptr_q <= flush_ptr_d;
            if (wr_fire)    valid_q[wr_idx_i][victim_way] <= 1'b1;
            if (flush_busy) valid_q[flush_ptr_q] <= '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (wr_fire) begin
            tag_q[wr_idx_i][victim_way]  <= wr_tag_i;
            data_q[wr_idx_i][victim_way] <= wr_data_i;
        end
    end

endmodule

// File: tb/tb_icache_mem_assoc.sv
// Directed plus random bench against a timestamp-based LRU cache model.
module tb_icache_mem_assoc;

    localparam int NS = 64;
    localparam int NW = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en;
    logic [5:0]  rd_idx;
    logic [22:0] rd_tag;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic [0:0]  rd_way;
    logic        wr_en;
    logic [5:0]  wr_idx;
    logic [22:0] wr_tag;
    logic [63:0] wr_data;
    logic        flush_req;
    logic        flush_busy;

    icache_mem_assoc dut (
        .clock_i      (clk),
        .reset_i      (reset),
        .rd_en_i      (rd_en),
        .rd_idx_i     (rd_idx),
        .rd_tag_i     (rd_tag),
        .rd_data_o    (rd_data),
        .rd_valid_o   (rd_valid),
        .rd_way_o     (rd_way),
        .wr_en_i      (wr_en),
        .wr_idx_i     (wr_idx),
        .wr_tag_i     (wr_tag),
        .wr_data_i    (wr_data),
        .flush_req_i  (flush_req),
        .flush_busy_o (flush_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: recency kept as a monotonically growing touch timestamp per way.
    bit          mvalid [NS][NW];
    logic [22:0] mtag   [NS][NW];
    logic [63:0] mdata  [NS][NW];
    longint      stamp  [NS][NW];
    longint      tick;
    int          busy_cnt;
    int          mptr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                mvalid[s][w] = 1'b0;
                stamp[s][w]  = -w;
            end
        end
        tick     = 0;
        busy_cnt = 0;
        mptr     = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; flush_req = 1'b0;
        rd_idx = '0; rd_tag = '0; wr_idx = '0; wr_tag = '0; wr_data = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic step(input bit re, input int ri, input int rt,
                        input bit we, input int wi, input int wt,
                        input logic [63:0] wd, input bit fr);
        bit          ev;
        int          ew;
        logic [63:0] ed;
        bit          busy;
        int          vic;
        rd_en = re; rd_idx = 6'(ri); rd_tag = 23'(rt);
        wr_en = we; wr_idx = 6'(wi); wr_tag = 23'(wt); wr_data = wd;
        flush_req = fr;
        #2;
        busy = (busy_cnt > 0);
        ev = 1'b0; ew = 0; ed = '0;
        if (re && !busy) begin
            for (int w = 0; w < NW; w++) begin
                if (!ev && mvalid[ri][w] && mtag[ri][w] == 23'(rt)) begin
                    ev = 1'b1; ew = w; ed = mdata[ri][w];
                end
            end
        end
        check("rd_valid", {63'd0, rd_valid}, {63'd0, ev});
        check("rd_way", {63'd0, rd_way}, 64'(ew));
        check("rd_data", rd_data, ed);
        check("flush_busy", {63'd0, flush_busy}, {63'd0, busy});
        if (ev) begin
            tick++;
            stamp[ri][ew] = tick;
        end
        if (we && !busy) begin
            vic = -1;
            for (int w = 0; w < NW; w++)
                if (vic < 0 && mvalid[wi][w] && mtag[wi][w] == 23'(wt)) vic = w;
            for (int w = 0; w < NW; w++)
                if (vic < 0 && !mvalid[wi][w]) vic = w;
            if (vic < 0) begin
                vic = 0;
                for (int w = 1; w < NW; w++)
                    if (stamp[wi][w] < stamp[wi][vic]) vic = w;
            end
            mvalid[wi][vic] = 1'b1;
            mtag[wi][vic]   = 23'(wt);
            mdata[wi][vic]  = wd;
            tick++;
            stamp[wi][vic] = tick;
        end
        if (busy) begin
            for (int w = 0; w < NW; w++) mvalid[mptr][w] = 1'b0;
            mptr++;
            busy_cnt--;
        end else if (fr) begin
            busy_cnt = NS;
            mptr     = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic rd(input int ri, input int rt);
        step(1'b1, ri, rt, 1'b0, 0, 0, 64'd0, 1'b0);
    endtask

    task automatic fill(input int wi, input int wt, input logic [63:0] wd);
        step(1'b0, 0, 0, 1'b1, wi, wt, wd, 1'b0);
    endtask

    initial begin
        do_reset();
        rd(5, 1);

        // Two fills into one set; the first fill is read in its own cycle and must miss.
        step(1'b1, 3, 'hA, 1'b1, 3, 'hA, 64'h1111, 1'b0);
        fill(3, 'hB, 64'h2222);
        rd(3, 'hA);
        check("hit_way_A", {63'd0, rd_way}, 64'd0);
        rd(3, 'hB);

        // LRU eviction: A touched, so B is the victim for C.
        do_reset();
        fill(3, 'hA, 64'hAAAA);
        fill(3, 'hB, 64'hBBBB);
        rd(3, 'hA);
        fill(3, 'hC, 64'hCCCC);
        rd(3, 'hA);
        rd(3, 'hC);
        rd(3, 'hB);

        // Refill of a resident tag overwrites in place.
        do_reset();
        fill(3, 'hA, 64'h1);
        fill(3, 'hA, 64'h2);
        rd(3, 'hA);
        fill(3, 'hD, 64'h3);
        rd(3, 'hA);
        rd(3, 'hD);

        // Full flush with writes attempted during the sweep; fill in the request cycle gets swept too.
        do_reset();
        for (int s = 0; s < 8; s++) fill(s * 7, s + 1, 64'(s) * 64'h1010);
        step(1'b0, 0, 0, 1'b1, 9, 'h55, 64'h5555, 1'b1);
        for (int c = 0; c < NS; c++)
            step(1'b1, 0, 1, 1'b1, c, 'h77, 64'h7777, 1'b1);
        for (int s = 0; s < 8; s++) rd(s * 7, s + 1);
        rd(9, 'h55);
        for (int c = 0; c < 4; c++) rd(c, 'h77);

        // Reset in the tenth flush cycle aborts the sweep.
        do_reset();
        for (int s = 0; s < 4; s++) fill(40 + s, 'h9, 64'h99);
        step(1'b0, 0, 0, 1'b0, 0, 0, 64'd0, 1'b1);
        for (int c = 0; c < 9; c++) rd(c, 'h9);
        do_reset();
        for (int s = 0; s < 4; s++) rd(40 + s, 'h9);

        // Random traffic over a few sets and tags to stress hits, evictions and same-set chaining.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            int wi;
            int ri;
            wi = int'($urandom_range(0, 3));
            ri = ($urandom_range(0, 2) == 0) ? wi : int'($urandom_range(0, 3));
            step(1'($urandom_range(0, 3) != 0), ri, int'($urandom_range(0, 4)),
                 1'($urandom_range(0, 1)), wi, int'($urandom_range(0, 4)),
                 {$urandom, $urandom}, 1'($urandom_range(0, 199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_mem_assoc.md
ICACHE_MEM_ASSOC -- requirements
Module: icache_mem_assoc

Interface
REQ-001 Parameter NUM_SETS, default 64, number of sets; power of two, >= 2.
REQ-002 Parameter NUM_WAYS, default 2, associativity; one of 1, 2, 4.
REQ-003 Parameter DATA_W, default 64, line data width in bits.
REQ-004 Parameter TAG_W, default 23, tag width in bits; IDX_W = log2(NUM_SETS), WAY_W = max(1, log2(NUM_WAYS)).
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rd_en  in  1  read lookup qualifier; when high, a hit updates replacement state.
REQ-008 rd_idx  in  IDX_W  read set index.
REQ-009 rd_tag  in  TAG_W  read tag.
REQ-010 rd_data  out  DATA_W  data of the hitting way; all-zero on miss.
REQ-011 rd_valid  out  1  hit indication.
REQ-012 rd_way  out  WAY_W  hitting way; 0 on miss.
REQ-013 wr_en  in  1  fill request.
REQ-014 wr_idx  in  IDX_W  fill set index.
REQ-015 wr_tag  in  TAG_W  fill tag.
REQ-016 wr_data  in  DATA_W  fill data.
REQ-017 flush_req  in  1  one-cycle pulse requesting invalidation of the whole cache.
REQ-018 flush_busy  out  1  high while the invalidation sweep runs.

Function
REQ-019 The read path SHALL be combinational: rd_valid = rd_en & !flush_busy & some way w has valid[rd_idx][w] and tag[rd_idx][w] == rd_tag.
REQ-020 A fill SHALL become visible to reads from the cycle after the wr_en edge; no same-cycle write-to-read bypass.
REQ-021 Fill victim: way already holding a valid matching wr_tag; else lowest-numbered invalid way; else the LRU way.
REQ-022 A fill SHALL write data and tag, set the victim's valid bit, and make the victim MRU.
REQ-023 A read hit with rd_en high SHALL make the hitting way MRU; misses leave replacement state unchanged.
REQ-024 Replacement SHALL be true LRU via per-way WAY_W-bit age counters per set: touched way -> 0, ways younger than its old age +1, others unchanged.
REQ-025 When a read hit and a fill target the same set in one cycle, the read update SHALL apply first and the fill update second (fill way ends MRU).
REQ-026 NUM_WAYS = 1 SHALL degenerate to direct-mapped with no age state.
REQ-027 FSM states IDLE and FLUSH; IDLE -> FLUSH on flush_req; FLUSH clears valid bits of set flush_ptr each cycle, flush_ptr counts 0 .. NUM_SETS-1, then FLUSH -> IDLE.
REQ-028 flush_busy SHALL be high exactly NUM_SETS cycles, starting the cycle after flush_req.
REQ-029 While flush_busy, wr_en SHALL be ignored, rd_valid SHALL be 0, and flush_req SHALL be ignored.
REQ-030 flush_req and wr_en in the same IDLE cycle: the fill is performed, then swept away by the flush.

Reset
REQ-031 Reset SHALL clear all valid bits, set ages of set s way w to w, return FSM to IDLE, clear flush_ptr; reset mid-flush aborts the sweep.
REQ-032 After reset: rd_valid = 0, rd_way = 0, rd_data = 0, flush_busy = 0; data and tag arrays are not reset.

Structure
REQ-033 A shared package SHALL hold the FSM state enum and the default parameter constants.
REQ-034 LRU age update SHALL be a sub-module icache_lru_update (old ages, touched way -> new ages), instanced twice for REQ-025 chaining.

Verification
REQ-035 Reset, read idx 5 tag 0x1 with rd_en -> rd_valid 0, rd_data 0.
REQ-036 Fill idx 3 tag 0xA data 0x1111, then tag 0xB data 0x2222 -> reads hit ways 0 and 1 with correct data; same-cycle read of a fill misses.
REQ-037 2-way: fill idx 3 tags A, B; read A; fill C -> B evicted, A and C hit.
REQ-038 Fill idx 3 tag A data 0x1 then tag A data 0x2 -> single way holds 0x2, other way stays invalid.
REQ-039 Fill several sets, pulse flush_req -> flush_busy high 64 cycles, wr_en ignored meanwhile, all reads miss afterwards.
REQ-040 Assert reset during cycle 10 of a flush -> flush_busy 0 next cycle, all valids clear.
